// File: rtl/fpalu_pkg.sv
// Shared constants and state encoding for the FPALU post-normalisation stage.
package fpalu_pkg;

    localparam int EXP_W      = 6;
    localparam int MAN_W      = 22;
    localparam int SHIFT_STEP = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_OUT   = 2'd2
    } fpnorm_state_e;

endpackage

// File: rtl/fpalu_lzc22.sv
// Combinational leading-zero counter over MAN_W bits.
// Returns MAN_W when the input is all zeros.
module fpalu_lzc22 #(
    parameter int MAN_W = 22,
    parameter int CNT_W = $clog2(MAN_W + 1)
) (
    input  logic [MAN_W-1:0] man,
    output logic [CNT_W-1:0] lzc
);

    logic found_s;

    // Priority scan from the MSB: the first set bit fixes the count.
    always_comb begin
        lzc     = CNT_W'(MAN_W);
        found_s = 1'b0;
        for (int i = MAN_W - 1; i >= 0; i--) begin
            if (!found_s && man[i]) begin
                lzc     = CNT_W'(MAN_W - 1 - i);
                found_s = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/fpalu_norm_stage.sv
// Post-normalisation stage behind the FPALU. Left-shifts leading zeros out of
// the mantissa (at most SHIFT_STEP per cycle), decrementing the exponent, until
// the mantissa is normalised, the exponent reaches zero, or the mantissa is zero.
// Optional macro FPNORM_FLAGS_EN adds registered out_zero / out_denorm flags.
module fpalu_norm_stage
    import fpalu_pkg::*;
#(
    parameter int EXP_W_P      = EXP_W,
    parameter int MAN_W_P      = MAN_W,
    parameter int SHIFT_STEP_P = SHIFT_STEP
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         in_sgn,
    input  logic [EXP_W_P-1:0]           in_exp,
    input  logic [MAN_W_P-1:0]           in_man_dn,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [EXP_W_P+MAN_W_P:0]     out_word
`ifdef FPNORM_FLAGS_EN
    ,
    output logic                         out_zero,
    output logic                         out_denorm
`endif
);

    localparam int CNT_W = $clog2(MAN_W_P + 1);
    localparam int CMP_W = ((EXP_W_P > CNT_W) ? EXP_W_P : CNT_W) + 1;

    fpnorm_state_e            state_r;
    logic                     in_ready_r;
    logic                     out_valid_r;
    logic [EXP_W_P+MAN_W_P:0] out_word_r;
    logic                     sgn_r;
    logic [EXP_W_P-1:0]       exp_r;
    logic [MAN_W_P-1:0]       man_r;
    logic [CNT_W-1:0]         lzc_s;
    logic [CMP_W-1:0]         step_s;
    logic [CMP_W-1:0]         lz_ext_s;
    logic [CMP_W-1:0]         exp_ext_s;
    logic [CMP_W-1:0]         step_lim_s;
    logic                     man_zero_s;
`ifdef FPNORM_FLAGS_EN
    logic                     zero_r;
    logic                     denorm_r;
`endif

    fpalu_lzc22 #(
        .MAN_W (MAN_W_P),
        .CNT_W (CNT_W)
    ) u_lzc (
        .man (man_r),
        .lzc (lzc_s)
    );

    assign lz_ext_s   = CMP_W'(lzc_s);
    assign exp_ext_s  = CMP_W'(exp_r);
    assign step_lim_s = CMP_W'(SHIFT_STEP_P);
    assign man_zero_s = (man_r == {MAN_W_P{1'b0}});

    // Shift amount for this cycle: min(leading zeros, per-cycle limit, exponent).
    always_comb begin
        step_s = lz_ext_s;
        if (step_lim_s < step_s) begin
            step_s = step_lim_s;
        end else begin
            step_s = step_s;
        end
        if (exp_ext_s < step_s) begin
            step_s = exp_ext_s;
        end else begin
            step_s = step_s;
        end
    end

    // Control FSM and datapath; all outputs registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            out_word_r  <= {(EXP_W_P + MAN_W_P + 1){1'b0}};
            sgn_r       <= 1'b0;
            exp_r       <= {EXP_W_P{1'b0}};
            man_r       <= {MAN_W_P{1'b0}};
`ifdef FPNORM_FLAGS_EN
            zero_r      <= 1'b0;
            denorm_r    <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid && in_ready_r) begin
                        sgn_r      <= in_sgn;
                        exp_r      <= in_exp;
                        man_r      <= in_man_dn;
                        in_ready_r <= 1'b0;
                        state_r    <= ST_SHIFT;
                    end else begin
                        in_ready_r <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (man_zero_s) begin
                        // True zero: exponent forced to 0, sign kept (-0 survives).
                        exp_r       <= {EXP_W_P{1'b0}};
                        out_word_r  <= {sgn_r, {EXP_W_P{1'b0}}, man_r};
                        out_valid_r <= 1'b1;
                        state_r     <= ST_OUT;
`ifdef FPNORM_FLAGS_EN
                        zero_r      <= 1'b1;
                        denorm_r    <= 1'b0;
`endif
                    end else if (man_r[MAN_W_P-1] || (exp_r == {EXP_W_P{1'b0}})) begin
                        out_word_r  <= {sgn_r, exp_r, man_r};
                        out_valid_r <= 1'b1;
                        state_r     <= ST_OUT;
`ifdef FPNORM_FLAGS_EN
                        zero_r      <= 1'b0;
                        denorm_r    <= (exp_r == {EXP_W_P{1'b0}});
`endif
                    end else begin
                        man_r <= man_r << step_s;
                        exp_r <= exp_r - EXP_W_P'(step_s);
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= ST_IDLE;
                    end else begin
                        out_valid_r <= 1'b1;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_word  = out_word_r;
`ifdef FPNORM_FLAGS_EN
    assign out_zero   = zero_r;
    assign out_denorm = denorm_r;
`endif

endmodule

// File: tb/tb_fpalu_norm_stage.sv
// Self-checking bench for fpalu_norm_stage: scoreboard of expected words,
// flags and latencies computed from a closed-form normalisation model.
module tb_fpalu_norm_stage;

    typedef struct {
        logic [28:0] word;
        logic        zero;
        logic        den;
        int          lat;
    } exp_rec_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_sgn;
    logic [5:0]  in_exp;
    logic [21:0] in_man_dn;
    logic        out_valid;
    logic        out_ready;
    logic [28:0] out_word;
    logic        out_zero;
    logic        out_denorm;

    int total;
    int bad;
    exp_rec_t exp_q[$];

    fpalu_norm_stage dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sgn    (in_sgn),
        .in_exp    (in_exp),
        .in_man_dn (in_man_dn),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_word  (out_word)
`ifdef FPNORM_FLAGS_EN
        ,
        .out_zero   (out_zero),
        .out_denorm (out_denorm)
`endif
    );

`ifndef FPNORM_FLAGS_EN
    assign out_zero   = 1'b0;
    assign out_denorm = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Closed-form model: total shift = min(lz, exp); one edge per SHIFT_STEP chunk plus one.
    function automatic exp_rec_t model(input logic s, input logic [5:0] e, input logic [21:0] m);
        exp_rec_t r;
        int lz;
        int sh;
        lz = 22;
        for (int i = 21; i >= 0; i--) begin
            if (m[i] && lz == 22) lz = 21 - i;
        end
        if (m == 22'd0) begin
            r.word = {s, 6'd0, 22'd0};
            r.zero = 1'b1;
            r.den  = 1'b0;
            r.lat  = 1;
        end else begin
            sh = (lz < int'(e)) ? lz : int'(e);
            r.word = {s, 6'(int'(e) - sh), 22'(m << sh)};
            r.zero = 1'b0;
            r.den  = (int'(e) == sh);
            r.lat  = 1 + (sh + 3) / 4;
        end
        return r;
    endfunction

    // Drive one op, push its expectation, wait for out_valid; consume it if out_ready is high.
    task automatic run_op(input logic s, input logic [5:0] e, input logic [21:0] m,
                          output logic [28:0] w, output int lat,
                          output logic z, output logic d);
        int wt;
        exp_q.push_back(model(s, e, m));
        wt = 0;
        while (!in_ready && wt < 50) begin
            @(posedge clk); #1; wt++;
        end
        if (!in_ready) begin
            total++; bad++;
            $display("FAIL ready_timeout: in_ready=%b required 1", in_ready);
        end
        in_valid = 1'b1; in_sgn = s; in_exp = e; in_man_dn = m;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        do begin
            @(posedge clk); #1; lat++;
        end while (!out_valid && lat < 100);
        w = out_word; z = out_zero; d = out_denorm;
        if (out_ready) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_sgn = 1'b0; in_exp = 6'd0; in_man_dn = 22'd0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        total++; if (out_word !== 29'd0) begin bad++; $display("FAIL rst_out_word: got %h want 0", out_word); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
        rst = 1'b0;
        @(posedge clk); #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL post_rst_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_directed();
        logic        s_t[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [5:0]  e_t[5] = '{6'h20, 6'h20, 6'h03, 6'h1F, 6'h00};
        logic [21:0] m_t[5] = '{22'h200000, 22'h000400, 22'h000001, 22'h000000, 22'h000010};
        logic [28:0] w; int lat; logic z; logic d; exp_rec_t r;
        for (int i = 0; i < 5; i++) begin
            run_op(s_t[i], e_t[i], m_t[i], w, lat, z, d);
            r = exp_q.pop_front();
            total++; if (w !== r.word) begin bad++; $display("FAIL dir%0d_word: got %h want %h", i, w, r.word); end
            total++; if (lat !== r.lat) begin bad++; $display("FAIL dir%0d_lat: got %0d want %0d", i, lat, r.lat); end
`ifdef FPNORM_FLAGS_EN
            total++; if (z !== r.zero) begin bad++; $display("FAIL dir%0d_zero: got %b want %b", i, z, r.zero); end
            total++; if (d !== r.den) begin bad++; $display("FAIL dir%0d_denorm: got %b want %b", i, d, r.den); end
`endif
        end
        // Hand-derived anchors for cases 2 and 3.
        run_op(1'b0, 6'h20, 22'h000400, w, lat, z, d);
        void'(exp_q.pop_front());
        total++; if (w !== {1'b0, 6'h15, 22'h200000}) begin bad++; $display("FAIL case2_const: got %h want %h", w, {1'b0, 6'h15, 22'h200000}); end
        run_op(1'b0, 6'h03, 22'h000001, w, lat, z, d);
        void'(exp_q.pop_front());
        total++; if (w !== {1'b0, 6'h00, 22'h000008}) begin bad++; $display("FAIL case3_const: got %h want %h", w, {1'b0, 6'h00, 22'h000008}); end
    endtask

    task automatic test_back_to_back();
        logic [28:0] w; int lat; logic z; logic d; exp_rec_t r;
        logic [21:0] m; logic [5:0] e; logic s;
        for (int i = 0; i < 24; i++) begin
            s = 1'($urandom_range(1, 0));
            e = 6'($urandom_range(63, 0));
            m = 22'($urandom) >> $urandom_range(22, 0);
            run_op(s, e, m, w, lat, z, d);
            r = exp_q.pop_front();
            total++; if (w !== r.word || lat !== r.lat) begin
                bad++; $display("FAIL rand%0d: got %h/%0d want %h/%0d", i, w, lat, r.word, r.lat);
            end
`ifdef FPNORM_FLAGS_EN
            total++; if (z !== r.zero || d !== r.den) begin
                bad++; $display("FAIL rand%0d_flags: got %b%b want %b%b", i, z, d, r.zero, r.den);
            end
`endif
        end
    endtask

    task automatic test_backpressure();
        logic [28:0] w; int lat; logic z; logic d; exp_rec_t r;
        out_ready = 1'b0;
        run_op(1'b0, 6'h20, 22'h000400, w, lat, z, d);
        r = exp_q.pop_front();
        total++; if (w !== r.word) begin bad++; $display("FAIL bp_word: got %h want %h", w, r.word); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            total++; if (out_word !== r.word || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                bad++; $display("FAIL bp_hold%0d: got %h v=%b r=%b want %h v=1 r=0", i, out_word, out_valid, in_ready, r.word);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL bp_release: got v=%b r=%b want v=0 r=1", out_valid, in_ready);
        end
        run_op(1'b0, 6'h03, 22'h000001, w, lat, z, d);
        r = exp_q.pop_front();
        total++; if (w !== r.word || lat !== r.lat) begin
            bad++; $display("FAIL bp_next: got %h/%0d want %h/%0d", w, lat, r.word, r.lat);
        end
    endtask

    task automatic test_reset_mid();
        logic [28:0] w; int lat; logic z; logic d; exp_rec_t r;
        in_valid = 1'b1; in_sgn = 1'b0; in_exp = 6'h20; in_man_dn = 22'h000400;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b0 || out_word !== 29'd0 || in_ready !== 1'b0) begin
            bad++; $display("FAIL mid_rst: got v=%b w=%h r=%b want v=0 w=0 r=0", out_valid, out_word, in_ready);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_stray_valid: got %b want 0", out_valid); end
        run_op(1'b0, 6'h20, 22'h200000, w, lat, z, d);
        r = exp_q.pop_front();
        total++; if (w !== r.word || lat !== r.lat) begin
            bad++; $display("FAIL mid_rst_next: got %h/%0d want %h/%0d", w, lat, r.word, r.lat);
        end
    endtask

    initial begin
        total = 0; bad = 0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
